// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : csr_access_ctrl
//  Purpose  : Initiator side of the CSR interface in the execute stage.
//             Sequences Zicsr read-modify-write accesses, the CSR traffic for
//             trap/interrupt entry (exception strobe + mtvec lookup) and mret
//             (mstatus update + mepc lookup). It returns old CSR values to the
//             pipeline and produces PC redirects.
//  Revision : 1.0  initial release
//
//  Optional feature macro: CSR_ACCESS_FAULT_EN
//    When defined, accesses to unmapped CSRs, and writes to the read-only
//    space (addr[11:10]==2'b11), raise an exception with cause 2 in place of
//    the access.
//
//  Ports
//    clk, nrst             clock, asynchronous active-low reset
//    req_*                 CSR instruction request (valid/ready handshake)
//    resp_valid/_rdata     one-cycle response carrying the old CSR value
//    trap_req/_cause/_pc   synchronous exception from the pipeline
//    irq, irq_pc           level external interrupt and its return PC
//    mret_req              mret retiring
//    redirect_valid/_pc    one-cycle fetch redirect
//    csr_raddr/_rdata      CSR file read port (combinational read data)
//    csr_waddr/_wdata      CSR file write port, qualified by csr_write
//    csr_exception*        exception strobe with cause and PC
//    csr_mie               mstatus.MIE from the CSR file
// ============================================================================
module csr_access_ctrl #(
  parameter int unsigned           XLEN      = 32,
  parameter int unsigned           ADDR_W    = 12,
  parameter logic [XLEN-1:0]       IRQ_CAUSE = 32'h8000000B
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_src,
  input  logic              req_src_zero,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic              irq,
  input  logic [XLEN-1:0]   irq_pc,
  input  logic              mret_req,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic [ADDR_W-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_write,
  output logic              csr_exception,
  output logic [XLEN-1:0]   csr_exception_cause,
  output logic [XLEN-1:0]   csr_exception_pc,
  input  logic              csr_mie
);

  localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] A_MTVEC   = ADDR_W'(12'h305);
  localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(12'h341);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TRAP_VEC = 3'd1,
    ST_CSR_RD   = 3'd2,
    ST_CSR_WR   = 3'd3,
    ST_MRET_ST  = 3'd4,
    ST_MRET_EPC = 3'd5
  } state_t;

  state_t              state_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     src_q;
  logic                src_zero_q;
  logic [XLEN-1:0]     old_q;
  // Only the interrupt flag and the bits that survive the <<2 are needed
  // for vectoring.
  logic                cause_irq_q;
  logic [XLEN-3:0]     cause_off_q;
`ifdef CSR_ACCESS_FAULT_EN
  logic [XLEN-1:0]     pc_q;
`endif

  logic                resp_valid_q;
  logic [XLEN-1:0]     resp_rdata_q;
  logic                redirect_valid_q;
  logic [XLEN-1:0]     redirect_pc_q;
  logic [ADDR_W-1:0]   csr_raddr_q;
  logic [ADDR_W-1:0]   csr_waddr_q;
  logic [XLEN-1:0]     csr_wdata_q;
  logic                csr_write_q;
  logic                csr_exc_q;
  logic [XLEN-1:0]     csr_exc_cause_q;
  logic [XLEN-1:0]     csr_exc_pc_q;

  logic                irq_taken_d;
  logic                wr_en_d;
  logic [XLEN-1:0]     new_d;
  logic [XLEN-1:0]     vec_pc_d;
  logic [XLEN-1:0]     mret_wdata_d;
`ifdef CSR_ACCESS_FAULT_EN
  logic                fault_d;
`endif

  always_comb begin
    irq_taken_d = irq && csr_mie;
    req_ready   = (state_q == ST_IDLE) && !trap_req && !irq_taken_d && !mret_req;

    // RS/RC with a zero source are reads only; op 00 never writes.
    wr_en_d = (op_q != 2'b00) && ((op_q == 2'b01) || !src_zero_q);

    case (op_q)
      2'b01:   new_d = src_q;
      2'b10:   new_d = csr_rdata | src_q;
      2'b11:   new_d = csr_rdata & ~src_q;
      default: new_d = csr_rdata;
    endcase

    // csr_rdata holds mtvec while in TRAP_VEC.
    vec_pc_d = {csr_rdata[XLEN-1:2], 2'b00};
    if ((csr_rdata[1:0] == 2'b01) && cause_irq_q) begin
      vec_pc_d = vec_pc_d + {cause_off_q, 2'b00};
    end

    // mret: MIE <- MPIE, MPIE <- 1.
    mret_wdata_d    = csr_rdata;
    mret_wdata_d[3] = csr_rdata[7];
    mret_wdata_d[7] = 1'b1;

`ifdef CSR_ACCESS_FAULT_EN
    fault_d = ((addr_q[ADDR_W-1 -: 2] == 2'b11) && wr_en_d) ||
              !(addr_q inside {ADDR_W'(12'h300), ADDR_W'(12'h310), ADDR_W'(12'h305),
                               ADDR_W'(12'h344), ADDR_W'(12'h304), ADDR_W'(12'h341),
                               ADDR_W'(12'h342), ADDR_W'(12'h340)});
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q          <= ST_IDLE;
      op_q             <= 2'b00;
      addr_q           <= '0;
      src_q            <= '0;
      src_zero_q       <= 1'b0;
      old_q            <= '0;
      cause_irq_q      <= 1'b0;
      cause_off_q      <= '0;
`ifdef CSR_ACCESS_FAULT_EN
      pc_q             <= '0;
`endif
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      csr_raddr_q      <= '0;
      csr_waddr_q      <= '0;
      csr_wdata_q      <= '0;
      csr_write_q      <= 1'b0;
      csr_exc_q        <= 1'b0;
      csr_exc_cause_q  <= '0;
      csr_exc_pc_q     <= '0;
    end else begin
      // Every output is a single-cycle event; default them back to zero.
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      csr_raddr_q      <= '0;
      csr_waddr_q      <= '0;
      csr_wdata_q      <= '0;
      csr_write_q      <= 1'b0;
      csr_exc_q        <= 1'b0;
      csr_exc_cause_q  <= '0;
      csr_exc_pc_q     <= '0;

      case (state_q)
        ST_IDLE: begin
          if (trap_req) begin
            state_q         <= ST_TRAP_VEC;
            csr_exc_q       <= 1'b1;
            csr_exc_cause_q <= trap_cause;
            csr_exc_pc_q    <= trap_pc;
            cause_irq_q     <= trap_cause[XLEN-1];
            cause_off_q     <= trap_cause[XLEN-3:0];
            csr_raddr_q     <= A_MTVEC;
          end else if (irq_taken_d) begin
            state_q         <= ST_TRAP_VEC;
            csr_exc_q       <= 1'b1;
            csr_exc_cause_q <= IRQ_CAUSE;
            csr_exc_pc_q    <= irq_pc;
            cause_irq_q     <= IRQ_CAUSE[XLEN-1];
            cause_off_q     <= IRQ_CAUSE[XLEN-3:0];
            csr_raddr_q     <= A_MTVEC;
          end else if (mret_req) begin
            state_q     <= ST_MRET_ST;
            csr_raddr_q <= A_MSTATUS;
          end else if (req_valid) begin
            state_q     <= ST_CSR_RD;
            op_q        <= req_op;
            addr_q      <= req_addr;
            src_q       <= req_src;
            src_zero_q  <= req_src_zero;
`ifdef CSR_ACCESS_FAULT_EN
            pc_q        <= trap_pc;
`endif
            csr_raddr_q <= req_addr;
          end
        end

        ST_TRAP_VEC: begin
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= vec_pc_d;
          state_q          <= ST_IDLE;
        end

        ST_CSR_RD: begin
          old_q <= csr_rdata;
`ifdef CSR_ACCESS_FAULT_EN
          if (fault_d) begin
            // Illegal access becomes an illegal-instruction trap.
            state_q         <= ST_TRAP_VEC;
            csr_exc_q       <= 1'b1;
            csr_exc_cause_q <= XLEN'(2);
            csr_exc_pc_q    <= pc_q;
            cause_irq_q     <= 1'b0;
            cause_off_q     <= (XLEN-2)'(2);
            csr_raddr_q     <= A_MTVEC;
          end else
`endif
          begin
            state_q <= ST_CSR_WR;
            if (wr_en_d) begin
              csr_write_q <= 1'b1;
              csr_waddr_q <= addr_q;
              csr_wdata_q <= new_d;
            end
          end
        end

        ST_CSR_WR: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= old_q;
          state_q      <= ST_IDLE;
        end

        ST_MRET_ST: begin
          csr_write_q <= 1'b1;
          csr_waddr_q <= A_MSTATUS;
          csr_wdata_q <= mret_wdata_d;
          csr_raddr_q <= A_MEPC;
          state_q     <= ST_MRET_EPC;
        end

        ST_MRET_EPC: begin
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= csr_rdata & ~XLEN'(3);
          state_q          <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid          = resp_valid_q;
  assign resp_rdata          = resp_rdata_q;
  assign redirect_valid      = redirect_valid_q;
  assign redirect_pc         = redirect_pc_q;
  assign csr_raddr           = csr_raddr_q;
  assign csr_waddr           = csr_waddr_q;
  assign csr_wdata           = csr_wdata_q;
  assign csr_write           = csr_write_q;
  assign csr_exception       = csr_exc_q;
  assign csr_exception_cause = csr_exc_cause_q;
  assign csr_exception_pc    = csr_exc_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_access_ctrl
//  Purpose  : Self-checking bench for csr_access_ctrl. A behavioural CSR file
//             answers the DUT; a transaction-level reference model predicts
//             writes, responses, exceptions and redirects.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_access_ctrl;

  localparam logic [31:0] IRQC = 32'h8000000B;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid, req_ready, req_src_zero;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_src;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        trap_req;
  logic [31:0] trap_cause, trap_pc;
  logic        irq;
  logic [31:0] irq_pc;
  logic        mret_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_write, csr_exception;
  logic [31:0] csr_exception_cause, csr_exception_pc;
  logic        csr_mie;

  always #5 clk = ~clk;

  csr_access_ctrl dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .irq(irq), .irq_pc(irq_pc), .mret_req(mret_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_write(csr_write),
    .csr_exception(csr_exception), .csr_exception_cause(csr_exception_cause),
    .csr_exception_pc(csr_exception_pc), .csr_mie(csr_mie)
  );

  // ---------------- behavioural CSR register file ----------------
  function automatic bit mapped(input logic [11:0] a);
    return a inside {12'h300, 12'h310, 12'h305, 12'h344,
                     12'h304, 12'h341, 12'h342, 12'h340};
  endfunction

  logic [31:0] rf [0:4095];
  logic        pk_en = 1'b0;
  logic [11:0] pk_addr = '0;
  logic [31:0] pk_data = '0;

  assign csr_rdata = mapped(csr_raddr) ? rf[csr_raddr] : 32'h0;

  always @(posedge clk) begin
    if (pk_en) rf[pk_addr] <= pk_data;
    else if (csr_write && mapped(csr_waddr)) rf[csr_waddr] <= csr_wdata;
  end

  // ---------------- reference model state ----------------
  logic [31:0] mdl [logic [11:0]];

  function automatic logic [31:0] mrd(input logic [11:0] a);
    if (mapped(a) && mdl.exists(a)) return mdl[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] vec_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = mtvec & ~32'h3;
    if (mtvec[1:0] == 2'b01 && cause[31]) return base + 32'(cause << 2);
    return base;
  endfunction

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- event observation ----------------
  int          o_wcnt, o_wk, o_rcnt, o_rk, o_xcnt, o_xk, o_dcnt, o_dk, o_both;
  logic [11:0] o_waddr;
  logic [31:0] o_wdata, o_rdata, o_xcause, o_xpc, o_dpc;

  // Sample ncyc falling edges; k=1 is the cycle right after the accept edge.
  task automatic observe(input int ncyc);
    o_wcnt = 0; o_wk = 0; o_rcnt = 0; o_rk = 0; o_xcnt = 0; o_xk = 0;
    o_dcnt = 0; o_dk = 0; o_both = 0;
    o_waddr = '0; o_wdata = '0; o_rdata = '0; o_xcause = '0; o_xpc = '0; o_dpc = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (csr_write)      begin o_wcnt++; o_wk = k; o_waddr = csr_waddr; o_wdata = csr_wdata; end
      if (resp_valid)     begin o_rcnt++; o_rk = k; o_rdata = resp_rdata; end
      if (csr_exception)  begin o_xcnt++; o_xk = k; o_xcause = csr_exception_cause; o_xpc = csr_exception_pc; end
      if (redirect_valid) begin o_dcnt++; o_dk = k; o_dpc = redirect_pc; end
      if (resp_valid && redirect_valid) o_both++;
    end
  endtask

  function automatic logic outputs_busy();
    return |{resp_valid, resp_rdata, redirect_valid, redirect_pc, csr_raddr, csr_waddr,
             csr_wdata, csr_write, csr_exception, csr_exception_cause, csr_exception_pc};
  endfunction

  task automatic clear_inputs();
    req_valid = 0; req_op = 0; req_addr = 0; req_src = 0; req_src_zero = 0;
    trap_req = 0; trap_cause = 0; trap_pc = 0; irq = 0; irq_pc = 0; mret_req = 0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    pk_en = 1; pk_addr = a; pk_data = d;
    @(negedge clk);
    pk_en = 0;
    mdl[a] = d;
  endtask

  // ---------------- transactions (each starts and ends at a falling edge) ----------------
  task automatic do_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src,
                        input logic sz, input logic [31:0] pc);
    logic [31:0] old, nw;
    bit          wr, fault;
    old = mrd(a);
    case (op)
      2'b01:   nw = src;
      2'b10:   nw = old | src;
      2'b11:   nw = old & ~src;
      default: nw = old;
    endcase
    wr    = (op != 2'b00) && !((op != 2'b01) && sz);
    fault = 0;
`ifdef CSR_ACCESS_FAULT_EN
    fault = ((a[11:10] == 2'b11) && wr) || !mapped(a);
`endif
    req_valid = 1; req_op = op; req_addr = a; req_src = src; req_src_zero = sz; trap_pc = pc;
    #1 chk("csr_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1 clear_inputs();
    observe(6);
    if (fault) begin
      chk("flt_wcnt", o_wcnt, 0);
      chk("flt_rcnt", o_rcnt, 0);
      chk("flt_xcnt", o_xcnt, 1);
      chk("flt_cause", o_xcause, 32'd2);
      chk("flt_pc", o_xpc, pc);
      chk("flt_dpc", o_dpc, vec_target(mrd(12'h305), 32'd2));
      chk("flt_dk", o_dk, 3);
    end else begin
      chk("csr_wcnt", o_wcnt, wr ? 1 : 0);
      if (wr) begin
        chk("csr_waddr", {20'b0, o_waddr}, {20'b0, a});
        chk("csr_wdata", o_wdata, nw);
        chk("csr_wk", o_wk, 2);
        if (mapped(a)) mdl[a] = nw;
      end
      chk("csr_rcnt", o_rcnt, 1);
      chk("csr_rdata", o_rdata, old);
      chk("csr_lat", o_rk, 3);
      chk("csr_xcnt", o_xcnt, 0);
      chk("csr_dcnt", o_dcnt, 0);
    end
    chk("excl", o_both, 0);
    chk("idle", {31'b0, outputs_busy()}, 32'd0);
  endtask

  // kind 0 = synchronous trap, 1 = interrupt
  task automatic do_trap(input bit kind, input logic [31:0] cause, input logic [31:0] pc,
                         input logic mie, input bit also_req);
    bit          taken;
    logic [31:0] ec;
    taken = (kind == 0) || mie;
    ec    = kind ? IRQC : cause;
    csr_mie = mie;
    if (kind == 0) begin trap_req = 1; trap_cause = cause; trap_pc = pc; end
    else begin irq = 1; irq_pc = pc; end
    if (also_req) begin req_valid = 1; req_op = 2'b01; req_addr = 12'h340; req_src = 32'hDEAD; end
    #1 chk("trap_ready", {31'b0, req_ready}, taken ? 32'd0 : 32'd1);
    @(posedge clk); #1 clear_inputs();
    observe(6);
    if (taken) begin
      chk("trap_xcnt", o_xcnt, 1);
      chk("trap_cause", o_xcause, ec);
      chk("trap_pc", o_xpc, pc);
      chk("trap_xk", o_xk, 1);
      chk("trap_dcnt", o_dcnt, 1);
      chk("trap_dpc", o_dpc, vec_target(mrd(12'h305), ec));
      chk("trap_dk", o_dk, 2);
    end else begin
      chk("irq_off_xcnt", o_xcnt, 0);
      chk("irq_off_dcnt", o_dcnt, 0);
    end
    chk("trap_wcnt", o_wcnt, 0);
    chk("trap_rcnt", o_rcnt, 0);
    chk("idle", {31'b0, outputs_busy()}, 32'd0);
  endtask

  task automatic do_mret();
    logic [31:0] old, nw;
    old = mrd(12'h300);
    nw  = (old & ~32'h88) | (old[7] ? 32'h8 : 32'h0) | 32'h80;
    mret_req = 1;
    #1 chk("mret_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1 clear_inputs();
    observe(6);
    chk("mret_wcnt", o_wcnt, 1);
    chk("mret_waddr", {20'b0, o_waddr}, 32'h300);
    chk("mret_wdata", o_wdata, nw);
    chk("mret_dcnt", o_dcnt, 1);
    chk("mret_dpc", o_dpc, mrd(12'h341) & ~32'h3);
    chk("mret_dk", o_dk, 3);
    chk("mret_xcnt", o_xcnt, 0);
    chk("idle", {31'b0, outputs_busy()}, 32'd0);
    mdl[12'h300] = nw;
  endtask

  // ---------------- main sequence ----------------
  logic [11:0] maddr [8] = '{12'h300, 12'h310, 12'h305, 12'h344,
                             12'h304, 12'h341, 12'h342, 12'h340};

  initial begin
    clear_inputs();
    csr_mie = 0;
    nrst = 0;
    @(negedge clk);
    foreach (maddr[i]) poke(maddr[i], 32'h0);
    chk("rst_idle", {31'b0, outputs_busy()}, 32'd0);
    nrst = 1;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    // CSRRS on mscratch, then with src_zero
    poke(12'h340, 32'hF0);
    do_csr(2'b10, 12'h340, 32'h0F, 0, 32'h0);
    poke(12'h340, 32'hF0);
    do_csr(2'b10, 12'h340, 32'h0F, 1, 32'h0);

    // CSRRC on mie
    poke(12'h304, 32'h888);
    do_csr(2'b11, 12'h304, 32'h8, 0, 32'h0);

    // Vectored interrupt, then masked interrupt
    poke(12'h305, 32'h8000_0001);
    do_trap(1, 32'h0, 32'h4000, 1, 0);
    do_trap(1, 32'h0, 32'h4000, 0, 0);

    // Trap racing a request
    poke(12'h305, 32'h200);
    do_trap(0, 32'd11, 32'h100, 0, 1);

    // mret
    poke(12'h300, 32'h80);
    poke(12'h341, 32'h1236);
    do_mret();

    // Reset in the middle of the write cycle
    req_valid = 1; req_op = 2'b01; req_addr = 12'h342; req_src = 32'h55;
    @(posedge clk); #1 clear_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_write", {31'b0, csr_write}, 32'd1);
    #1 nrst = 0;
    #1 chk("rst_write_drop", {31'b0, csr_write}, 32'd0);
    @(negedge clk);
    nrst = 1;
    #1 chk("rst_rel_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rel_idle", {31'b0, outputs_busy()}, 32'd0);
    @(negedge clk);
    do_csr(2'b00, 12'h342, 32'h0, 1, 32'h0);

    // Write to read-only/unmapped space
    do_csr(2'b01, 12'hF11, 32'h5, 0, 32'hABC);

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      int unsigned kind;
      logic [11:0] a;
      logic [31:0] s;
      logic        z;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        case ($urandom_range(0, 7))
          0:       a = 12'hF11;
          1:       a = 12'($urandom);
          default: a = maddr[$urandom_range(0, 7)];
        endcase
        z = ($urandom_range(0, 3) == 0);
        s = z ? 32'h0 : $urandom;
        do_csr(2'($urandom), a, s, z, $urandom);
      end else if (kind == 6) begin
        do_trap(0, $urandom & 32'h8000_001F, $urandom, 1'($urandom), 1'($urandom));
      end else if (kind == 7) begin
        do_trap(1, 32'h0, $urandom, 1'($urandom), 0);
      end else if (kind == 8) begin
        do_mret();
      end else begin
        poke(12'h305, ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
